mac_vec_acc: RTL

Parametrised multi-lane signed multiply-accumulate engine for vector dot products. Each accepted beat multiplies LANES signed operand pairs, sums them, and accumulates the sum over VEC_LEN beats. When the vector is complete it emits a single registered result with a valid pulse. It sits between the operand fetch logic and the result collector of the matrix multiplier and replaces the fixed single-lane DSP MAC.

---
 rtl/mac_vec_pkg.sv | 40 ++++
 rtl/mac_vec_acc_lane_sum.sv | 62 ++++++
 rtl/mac_vec_acc.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mac_vec_pkg.sv
// mac_vec_pkg: shared types and width helpers for the vector MAC engine.
// Optional saturation is enabled by defining MAC_VEC_ACC_SAT_EN.
package mac_vec_pkg;

   // state | meaning
   // IDLE  | beat counter is 0, no partial vector held
   // ACC   | 1 <= counter <= VEC_LEN-1, vector partially accumulated
   typedef enum logic {
      IDLE = 1'b0,
      ACC  = 1'b1
   } state_t;

   localparam int DEF_DATA_W  = 8;
   localparam int DEF_LANES   = 4;
   localparam int DEF_VEC_LEN = 16;
   localparam int DEF_ACC_W   = 32;

   function automatic int prod_w(input int data_w);
      return 2 * data_w;
   endfunction

   function automatic int lsum_w(input int data_w, input int lanes);
      return 2 * data_w + $clog2(lanes);
   endfunction

   // A one-beat vector still needs a 1-bit counter to stay well formed.
   function automatic int cnt_w(input int vec_len);
      return (vec_len > 1) ? $clog2(vec_len) : 1;
   endfunction

   localparam int PROD_W = prod_w(DEF_DATA_W);
   localparam int LSUM_W = lsum_w(DEF_DATA_W, DEF_LANES);
   localparam int CNT_W  = cnt_w(DEF_VEC_LEN);

   // Saturation bounds for the default accumulator width; the top derives
   // the same pattern for its own ACC_W.
   localparam logic signed [DEF_ACC_W-1:0] SAT_MAX = {1'b0, {(DEF_ACC_W-1){1'b1}}};
   localparam logic signed [DEF_ACC_W-1:0] SAT_MIN = {1'b1, {(DEF_ACC_W-1){1'b0}}};

endpackage

// File: rtl/mac_vec_acc_lane_sum.sv
// mac_lane_sum: LANES signed multipliers, balanced adder tree and the
// stage-1 register carrying the first/last beat tags.
module mac_lane_sum
   import mac_vec_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int LANES  = DEF_LANES
) (
   input  logic                                    clk_i,
   input  logic                                    rstn_i,
   input  logic                                    en_i,
   input  logic                                    clear_i,
   input  logic                                    valid_i,
   input  logic                                    first_i,
   input  logic                                    last_i,
   input  logic [LANES*DATA_W-1:0]                 a_i,
   input  logic [LANES*DATA_W-1:0]                 b_i,
   output logic                                    valid_o,
   output logic                                    first_o,
   output logic                                    last_o,
   output logic signed [lsum_w(DATA_W, LANES)-1:0] sum_o
);

   localparam int P_W  = prod_w(DATA_W);
   localparam int LS_W = lsum_w(DATA_W, LANES);

   logic signed [P_W-1:0]  prod [LANES];
   logic signed [LS_W-1:0] node [2*LANES-1];

   // Lane products feed the leaves of a heap-ordered tree; node 0 is the root.
   always_comb begin
      for (int j = 0; j < 2*LANES-1; j++) node[j] = '0;
      for (int j = 0; j < LANES; j++) begin
         prod[j] = P_W'($signed(a_i[j*DATA_W +: DATA_W])) *
                   P_W'($signed(b_i[j*DATA_W +: DATA_W]));
         node[LANES-1+j] = LS_W'(prod[j]);
      end
      for (int i = LANES-2; i >= 0; i--) begin
         node[i] = node[2*i+1] + node[2*i+2];
      end
   end

   // Stage-1 register: clear drops the tags, en_i=0 freezes everything.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         valid_o <= 1'b0;
         first_o <= 1'b0;
         last_o  <= 1'b0;
         sum_o   <= '0;
      end else if (clear_i) begin
         valid_o <= 1'b0;
         first_o <= 1'b0;
         last_o  <= 1'b0;
      end else if (en_i) begin
         valid_o <= valid_i;
         first_o <= first_i;
         last_o  <= last_i;
         sum_o   <= node[0];
      end
   end

endmodule

// File: rtl/mac_vec_acc.sv
// mac_vec_acc: multi-lane signed dot-product engine. Beats are counted by an
// IDLE/ACC FSM, lane sums come from mac_lane_sum, and the top accumulates and
// registers one result per VEC_LEN beats.
// Define MAC_VEC_ACC_SAT_EN for a saturating accumulator with sticky ovf_o;
// otherwise the accumulator wraps and ovf_o is 0.
module mac_vec_acc
   import mac_vec_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int LANES   = 4,
   parameter int VEC_LEN = 16,
   parameter int ACC_W   = 32
) (
   input  logic                    clk_i,
   input  logic                    rstn_i,
   input  logic                    en_i,
   input  logic                    clear_i,
   input  logic                    valid_i,
   input  logic [LANES*DATA_W-1:0] a_i,
   input  logic [LANES*DATA_W-1:0] b_i,
   output logic                    busy_o,
   output logic                    out_valid_o,
   output logic signed [ACC_W-1:0] out_data_o,
   output logic                    ovf_o
);

   localparam int LS_W  = lsum_w(DATA_W, LANES);
   localparam int C_W   = cnt_w(VEC_LEN);
   localparam logic [C_W-1:0] CNT_LAST = C_W'(VEC_LEN-1);

   state_t           state_q, state_d;
   logic [C_W-1:0]   cnt_q, cnt_d;
   logic             accept, first_beat, last_beat;

   logic             s1_valid, s1_first, s1_last;
   logic signed [LS_W-1:0]  s1_sum;
   logic signed [ACC_W-1:0] sum_ext, acc_base, acc_nxt, acc_q, out_data_q;
   logic             out_valid_q;

   assign accept     = valid_i & en_i & ~clear_i;
   assign first_beat = (cnt_q == '0);
   assign last_beat  = (cnt_q == CNT_LAST);
   assign busy_o     = (state_q == ACC);

   // Beat counter and state register.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: the last beat returns to IDLE so the next vector can start
   // in the following cycle without a bubble.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (clear_i) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else if (accept) begin
         if (last_beat) begin
            state_d = IDLE;
            cnt_d   = '0;
         end else begin
            state_d = ACC;
            cnt_d   = cnt_q + 1'b1;
         end
      end
   end

   mac_lane_sum #(
      .DATA_W (DATA_W),
      .LANES  (LANES)
   ) u_lane_sum (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .en_i    (en_i),
      .clear_i (clear_i),
      .valid_i (accept),
      .first_i (first_beat),
      .last_i  (last_beat),
      .a_i     (a_i),
      .b_i     (b_i),
      .valid_o (s1_valid),
      .first_o (s1_first),
      .last_o  (s1_last),
      .sum_o   (s1_sum)
   );

   assign sum_ext  = ACC_W'(s1_sum);
   assign acc_base = s1_first ? '0 : acc_q;

`ifdef MAC_VEC_ACC_SAT_EN
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   logic signed [ACC_W:0] sum_wide;
   logic                  sat_hit, ovf_nxt, ovf_q, ovf_out_q;

   // One guard bit exposes overflow; clamp toward the sign of the true sum.
   always_comb begin
      sum_wide = {acc_base[ACC_W-1], acc_base} + {sum_ext[ACC_W-1], sum_ext};
      sat_hit  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
      acc_nxt  = sum_wide[ACC_W-1:0];
      if (sat_hit) acc_nxt = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
      ovf_nxt  = (s1_first ? 1'b0 : ovf_q) | sat_hit;
   end

   // Sticky per-vector saturation flag, latched out alongside the result.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         ovf_q     <= 1'b0;
         ovf_out_q <= 1'b0;
      end else if (clear_i) begin
         ovf_q     <= 1'b0;
      end else if (en_i && s1_valid) begin
         ovf_q <= ovf_nxt;
         if (s1_last) ovf_out_q <= ovf_nxt;
      end
   end

   assign ovf_o = ovf_out_q;
`else
   assign acc_nxt = acc_base + sum_ext;
   assign ovf_o   = 1'b0;
`endif

   // Accumulator and result registers; out_data_o survives a clear.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else if (clear_i) begin
         acc_q       <= '0;
         out_valid_q <= 1'b0;
      end else if (en_i) begin
         out_valid_q <= s1_valid & s1_last;
         if (s1_valid) acc_q <= acc_nxt;
         if (s1_valid && s1_last) out_data_q <= acc_nxt;
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;

endmodule
